// File: rtl/sp_fifo_ctrl.sv
// sp_fifo_ctrl: valid/ready stream FIFO built on a single-port RAM with a
// shared bidirectional data bus. Writes win the port in any one cycle. A
// fairness flag hands the following cycle to a starved read, and popped words
// are presented through a one-entry output register.
module sp_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // push side
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    // pop side
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    // status
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    // single-port RAM
    output logic                       ram_wren,
    output logic [$clog2(DEPTH)-1:0]   ram_addr,
    inout  wire  [WIDTH-1:0]           ram_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_prio_q, rd_prio_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;

    logic wr_fire;
    logic rd_elig;
    logic rd_issue;

    // Port arbitration: push handshake, read eligibility, and the RAM port drive.
    always_comb begin
        full     = (count_q == DEPTH_C);
        // Gating with rst_n keeps the bus released and pushes refused while the
        // shared reset is asserted, before the state registers have settled.
        s_ready  = rst_n && !full && !rd_pend_q && !rd_prio_q;
        wr_fire  = s_valid && s_ready;
        rd_elig  = (count_q != '0) && !rd_pend_q && (!m_valid_q || m_ready);
        rd_issue = rd_elig && !wr_fire;
        ram_wren = wr_fire;
        // Idle cycles present rptr so the RAM does a harmless read.
        ram_addr = wr_fire ? wptr_q : rptr_q;
    end

    // The controller only drives the bus during its own write cycles.
    assign ram_data = wr_fire ? s_data : 'z;

    assign count   = count_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    // Next-state logic for pointers, occupancy, read pipeline and output register.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        rd_pend_d = rd_issue;
        rd_prio_d = rd_prio_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        // Pointers wrap explicitly so DEPTH need not be a power of two.
        if (wr_fire) begin
            wptr_d  = (wptr_q == LAST_C) ? '0 : wptr_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (rd_issue) begin
            rptr_d  = (rptr_q == LAST_C) ? '0 : rptr_q + 1'b1;
            count_d = count_q - 1'b1;
        end

        // A read that lost the port to a write gets the next cycle.
        if (rd_issue) begin
            rd_prio_d = 1'b0;
        end else if (rd_elig && wr_fire) begin
            rd_prio_d = 1'b1;
        end

        // Capture cycle: the RAM drives the word read in the previous cycle.
        // The output register is always free here, so capture never collides
        // with a pop.
        if (rd_pend_q) begin
            m_valid_d = 1'b1;
            m_data_d  = ram_data;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_prio_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
            rd_prio_q <= rd_prio_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Directed bench for sp_fifo_ctrl. Three controllers (DEPTH 128, 4 and 5)
// share the stimulus, and each has its own behavioural single-port RAM with a
// registered read that drives the bus whenever wren is low.
module tb_sp_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // ---------------- instance A: DEPTH=128 ----------------
    logic       s_ready_a, m_valid_a, full_a, ram_wren_a;
    logic [7:0] m_data_a;
    logic [7:0] count_a;
    logic [6:0] ram_addr_a;
    wire  [7:0] ram_data_a;
    logic [7:0] mem_a [128];
    logic [7:0] rd_a;

    sp_fifo_ctrl #(.WIDTH(8), .DEPTH(128)) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .count(count_a), .full(full_a),
        .ram_wren(ram_wren_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a)
    );
    always @(posedge clk) if (ram_wren_a) mem_a[ram_addr_a] <= ram_data_a; else rd_a <= mem_a[ram_addr_a];
    assign ram_data_a = ram_wren_a ? 8'bz : rd_a;

    // ---------------- instance B: DEPTH=4 ----------------
    logic       s_ready_b, m_valid_b, full_b, ram_wren_b;
    logic [7:0] m_data_b;
    logic [2:0] count_b;
    logic [1:0] ram_addr_b;
    wire  [7:0] ram_data_b;
    logic [7:0] mem_b [4];
    logic [7:0] rd_b;

    sp_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .count(count_b), .full(full_b),
        .ram_wren(ram_wren_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b)
    );
    always @(posedge clk) if (ram_wren_b) mem_b[ram_addr_b] <= ram_data_b; else rd_b <= mem_b[ram_addr_b];
    assign ram_data_b = ram_wren_b ? 8'bz : rd_b;

    // ---------------- instance C: DEPTH=5 ----------------
    logic       s_ready_c, m_valid_c, full_c, ram_wren_c;
    logic [7:0] m_data_c;
    logic [3:0] count_c;
    logic [2:0] ram_addr_c;
    wire  [7:0] ram_data_c;
    logic [7:0] mem_c [8];
    logic [7:0] rd_c;

    sp_fifo_ctrl #(.WIDTH(8), .DEPTH(5)) u_c (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready_c), .s_data(s_data),
        .m_valid(m_valid_c), .m_ready(m_ready), .m_data(m_data_c),
        .count(count_c), .full(full_c),
        .ram_wren(ram_wren_c), .ram_addr(ram_addr_c), .ram_data(ram_data_c)
    );
    always @(posedge clk) if (ram_wren_c) mem_c[ram_addr_c] <= ram_data_c; else rd_c <= mem_c[ram_addr_c];
    assign ram_data_c = ram_wren_c ? 8'bz : rd_c;

    // Each cycle starts 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (s_ready_a !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready_a); end
        vectors++; if (ram_wren_a !== 1'b0) begin errors++; $display("FAIL reset_ram_wren got %b want 0", ram_wren_a); end
        vectors++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid_a); end
        vectors++; if (m_data_a !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data_a); end
        vectors++; if (count_a !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_a); end
        vectors++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_a); end
        next_cycle();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        vectors++; if (s_ready_a !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %b want 1", s_ready_a); end
        next_cycle();
    endtask

    task automatic test_latency();
        apply_reset();
        // cycle 0: push
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        @(negedge clk);
        vectors++; if (ram_wren_a !== 1'b1) begin errors++; $display("FAIL lat_c0_wren got %b want 1", ram_wren_a); end
        vectors++; if (ram_addr_a !== 7'd0) begin errors++; $display("FAIL lat_c0_addr got %0d want 0", ram_addr_a); end
        next_cycle();
        // cycle 1: read issue of address 0
        s_valid = 1'b0;
        @(negedge clk);
        vectors++; if (ram_wren_a !== 1'b0) begin errors++; $display("FAIL lat_c1_wren got %b want 0", ram_wren_a); end
        vectors++; if (ram_addr_a !== 7'd0) begin errors++; $display("FAIL lat_c1_addr got %0d want 0", ram_addr_a); end
        vectors++; if (count_a !== 8'd1) begin errors++; $display("FAIL lat_c1_count got %0d want 1", count_a); end
        next_cycle();
        // cycle 2: capture
        @(negedge clk);
        vectors++; if (count_a !== 8'd0) begin errors++; $display("FAIL lat_c2_count got %0d want 0", count_a); end
        vectors++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL lat_c2_m_valid got %b want 0", m_valid_a); end
        next_cycle();
        // cycle 3: word visible
        @(negedge clk);
        vectors++; if (m_valid_a !== 1'b1) begin errors++; $display("FAIL lat_c3_m_valid got %b want 1", m_valid_a); end
        vectors++; if (m_data_a !== 8'hA5) begin errors++; $display("FAIL lat_c3_m_data got %h want a5", m_data_a); end
        next_cycle();
        // cycle 4: popped
        @(negedge clk);
        vectors++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL lat_c4_m_valid got %b want 0", m_valid_a); end
        vectors++; if (count_a !== 8'd0) begin errors++; $display("FAIL lat_c4_count got %0d want 0", count_a); end
        next_cycle();
    endtask

    task automatic test_fill_drain();
        int word;
        int acc;
        int popped;
        logic fire;
        apply_reset();
        word = 1; acc = 0;
        for (int k = 0; k < 16; k++) begin
            s_valid = (word <= 6);
            s_data  = 8'(word);
            @(negedge clk);
            fire = s_valid && s_ready_b;
            if (fire) acc++;
            next_cycle();
            if (fire) word++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        vectors++; if (acc !== 5) begin errors++; $display("FAIL fill_accepted got %0d want 5", acc); end
        vectors++; if (full_b !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_b); end
        vectors++; if (count_b !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count_b); end
        vectors++; if (s_ready_b !== 1'b0) begin errors++; $display("FAIL fill_s_ready got %b want 0", s_ready_b); end
        vectors++; if (m_data_b !== 8'd1) begin errors++; $display("FAIL fill_m_data got %0d want 1", m_data_b); end
        next_cycle();
        m_ready = 1'b1;
        popped  = 0;
        for (int k = 0; k < 40 && popped < 5; k++) begin
            @(negedge clk);
            if (m_valid_b) begin
                vectors++;
                if (m_data_b !== 8'(popped + 1)) begin
                    errors++; $display("FAIL drain_word%0d got %0d want %0d", popped, m_data_b, popped + 1);
                end
                popped++;
            end
            next_cycle();
        end
        vectors++; if (popped !== 5) begin errors++; $display("FAIL drain_count got %0d want 5", popped); end
        m_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] exp_w;
        int pushed;
        int popped;
        logic fire;
        apply_reset();
        pushed = 0; popped = 0;
        for (int k = 0; k < 3000 && popped < 23; k++) begin
            s_valid = (pushed < 23) && ($urandom_range(0, 1) == 1);
            s_data  = 8'(8'h10 + pushed);
            m_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            vectors++;
            if (ram_addr_c > 3'd4) begin errors++; $display("FAIL wrap_addr got %0d want <=4", ram_addr_c); end
            fire = s_valid && s_ready_c;
            if (fire) exp_q.push_back(s_data);
            if (m_valid_c && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL wrap_pop got %h want nothing (queue empty)", m_data_c);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data_c !== exp_w) begin errors++; $display("FAIL wrap_word%0d got %h want %h", popped, m_data_c, exp_w); end
                end
                popped++;
            end
            next_cycle();
            if (fire) pushed++;
        end
        vectors++; if (popped !== 23) begin errors++; $display("FAIL wrap_popped got %0d want 23", popped); end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_fairness();
        logic [7:0] word;
        logic [7:0] pop_word;
        logic fire;
        logic exp_w;
        apply_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        word = 8'h40; pop_word = 8'h40;
        for (int k = 0; k < 16; k++) begin
            s_data = word;
            @(negedge clk);
            vectors++;
            if ((^ram_data_a) === 1'bx) begin errors++; $display("FAIL fair_bus_c%0d got %h want no X", k, ram_data_a); end
            if (k >= 4) begin
                exp_w = ((k - 4) % 3 == 0);
                vectors++; if (ram_wren_a !== exp_w) begin errors++; $display("FAIL fair_wren_c%0d got %b want %b", k, ram_wren_a, exp_w); end
                vectors++; if (s_ready_a !== exp_w) begin errors++; $display("FAIL fair_s_ready_c%0d got %b want %b", k, s_ready_a, exp_w); end
                vectors++; if (m_valid_a !== exp_w) begin errors++; $display("FAIL fair_m_valid_c%0d got %b want %b", k, m_valid_a, exp_w); end
            end
            if (m_valid_a) begin
                vectors++;
                if (m_data_a !== pop_word) begin errors++; $display("FAIL fair_m_data_c%0d got %h want %h", k, m_data_a, pop_word); end
                pop_word++;
            end
            fire = ram_wren_a;
            next_cycle();
            if (fire) word++;
        end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc;
        bit got;
        logic fire;
        apply_reset();
        acc = 0;
        for (int k = 0; k < 20 && acc < 5; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h21 + acc);
            @(negedge clk);
            fire = s_ready_b;
            next_cycle();
            if (fire) acc++;
        end
        s_valid = 1'b0;
        next_cycle();
        // pop the output word; this also issues a read (count 4 -> 3)
        m_ready = 1'b1;
        @(negedge clk);
        vectors++; if (count_b !== 3'd4) begin errors++; $display("FAIL mid_pre_count got %0d want 4", count_b); end
        vectors++; if (m_valid_b !== 1'b1) begin errors++; $display("FAIL mid_pre_m_valid got %b want 1", m_valid_b); end
        next_cycle();
        // capture cycle with 3 words stored: reset here
        m_ready = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        vectors++; if (count_b !== 3'd3) begin errors++; $display("FAIL mid_pend_count got %0d want 3", count_b); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (m_valid_b !== 1'b0) begin errors++; $display("FAIL mid_post_m_valid got %b want 0", m_valid_b); end
        vectors++; if (count_b !== 3'd0) begin errors++; $display("FAIL mid_post_count got %0d want 0", count_b); end
        next_cycle();
        s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
        @(negedge clk);
        vectors++; if (s_ready_b !== 1'b1) begin errors++; $display("FAIL mid_push_ready got %b want 1", s_ready_b); end
        next_cycle();
        s_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (m_valid_b) begin
                got = 1'b1;
                vectors++;
                if (m_data_b !== 8'h3C) begin errors++; $display("FAIL mid_pop_data got %h want 3c", m_data_b); end
            end
            next_cycle();
        end
        vectors++; if (got !== 1'b1) begin errors++; $display("FAIL mid_pop_timeout got %b want 1", got); end
        m_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 4; i++)   mem_b[i] = 8'h00;
        for (int i = 0; i < 8; i++)   mem_c[i] = 8'h00;
        rd_a = 8'h00; rd_b = 8'h00; rd_c = 8'h00;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_fill_drain();
        test_wrap();
        test_fairness();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
